tt_adder_arbiter: RTL and testbench
===================================

# tt_adder_arbiter

Round-robin arbiter and sequencer sharing one registered WIDTH-bit adder between NREQ requesters.
- Each requester presents an operand pair on a valid/ready handshake.
- The granted pair is summed and held in a one-deep result register, returned on a valid/ready response channel tagged with the requester ID.
- Sits between the Tiny Tapeout top-level I/O decode and the shared adder datapath, replacing the fixed `ui_in + uio_in` wiring when several sources need the adder.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 8: operand and sum width.
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `req_valid` in, NREQ: per-requester operand pair valid.
- `req_ready` out, NREQ: per-requester accept; at most one bit high.
- `req_a` in, NREQ*WIDTH: operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b` in, NREQ*WIDTH: operand B; same packing as `req_a`.
- `rsp_valid` out, 1: result register holds an unconsumed result.
- `rsp_ready` in, 1: consumer accepts the result.
- `rsp_sum` out, WIDTH: registered sum.
- `rsp_carry` out, 1: registered carry-out; saturation flag when `TT_ADDER_ARB_SAT_EN` is defined.
- `rsp_id` out, $clog2(NREQ): index of the requester that produced the result.

## Operation
- Priority pointer `ptr` (0..NREQ-1).
  - Grant = first i with `req_valid[i]`, searching i = ptr, ptr+1, … modulo NREQ.
- `can_accept` = !`rsp_valid` || `rsp_ready`.
- `req_ready[grant]` = `can_accept` && any `req_valid`. All other `req_ready` bits are 0.
  - `req_ready` depends combinationally on `req_valid` and `rsp_ready`.
  - Requesters must not gate valid on ready.
- Accept (`req_valid[g]` && `req_ready[g]`) loads the result register:
  - `{rsp_carry, rsp_sum}` = `req_a[g]` + `req_b[g]`, computed at WIDTH+1 bits.
  - `rsp_id` = g.
  - `rsp_valid` = 1.
  - `ptr` = (g+1) mod NREQ.
- Response handshake (`rsp_valid` && `rsp_ready`) with no accept in the same cycle: `rsp_valid` = 0; data fields hold their last values.
- Handshake and accept in the same cycle: the new result replaces the old one, `rsp_valid` stays 1. This gives full throughput of one operation per cycle.
- `ptr` advances only on an accept, never on an idle cycle.
- A requester holding valid low is skipped without penalty.
- Effective state machine, two states:
  - EMPTY (`rsp_valid`=0) → FULL on accept.
  - FULL → EMPTY on a response handshake without an accept.
  - FULL → FULL on a simultaneous handshake and accept, or while stalled.
- While FULL and `rsp_ready`=0: all `req_ready` = 0, and `rsp_sum`, `rsp_carry`, `rsp_id` are stable.

## Timing
- Reset values (asynchronous, immediate): `rsp_valid`=0, `rsp_sum`=0, `rsp_carry`=0, `rsp_id`=0, `ptr`=0.
- `req_ready` = 0 while `rst` is high.
- Latency: accept at edge N → `rsp_valid`=1 with the result after edge N; visible in cycle N+1.
- Reset mid-operation discards any held result; no response is emitted for it.
- Deassertion of `rst` must be synchronized externally; the block treats release as synchronous to `clk`.
- Starvation bound: a requester holding valid is granted within NREQ accepts.

## Configuration
- `TT_ADDER_ARB_SAT_EN` defined: unsigned saturation.
  - If the WIDTH+1-bit sum exceeds 2^WIDTH−1, `rsp_sum` = all ones and `rsp_carry` = 1 (saturation flag).
  - Otherwise `rsp_carry` = 0.
- Undefined: modular sum; `rsp_sum` wraps and `rsp_carry` is the true carry-out.
- Handshake, latency and arbitration are identical in both builds.

## Structure
- Package `tt_adder_arb_pkg`:
  - `ADDER_WIDTH` default (8).
  - `ADDER_NREQ` default (4).
  - `req_id_t` typedef.
  - Function `sat_add(a, b)` returning the {carry, sum} pair.
- Sub-module `tt_rr_arbiter`:
  - Combinational grant from `req_valid` and `ptr`, producing a one-hot grant plus its encoded index.
  - Pointer update stays in the parent.
- Parent holds `ptr`, the result register and the handshake logic.

## Test plan
- Reset then idle:
  - Stimulus: `rst`=1, then 0, with no valids.
  - Required: all outputs 0, `req_ready`=0 for 10 cycles.
- Single add:
  - Stimulus: requester 2 sends a=0x12, b=0x34; `rsp_ready`=1.
  - Required: next cycle `rsp_valid`=1, `rsp_sum`=0x46, `rsp_carry`=0, `rsp_id`=2.
- Overflow:
  - Stimulus: a=0xF0, b=0x20.
  - Required: `rsp_sum`=0x10, `rsp_carry`=1 without the macro; `rsp_sum`=0xFF, `rsp_carry`=1 with `TT_ADDER_ARB_SAT_EN`.
- Round robin:
  - Stimulus: all four requesters valid continuously, `rsp_ready`=1.
  - Required: `rsp_id` sequence 0,1,2,3,0,1…; one result every cycle.
- Backpressure:
  - Stimulus: result held with `rsp_ready`=0 for 5 cycles while requesters 1 and 3 are valid.
  - Required: `req_ready`=0 and the outputs stable throughout.
  - Required: on `rsp_ready`=1, requester 1 is accepted in that same cycle.
- Reset mid-stall:
  - Stimulus: assert `rst` while FULL.
  - Required: `rsp_valid` drops immediately; after release, `ptr`=0, so requester 0 wins when all are valid.

Source files
------------

// File: rtl/tt_adder_arb_pkg.sv
// Shared types and the {carry, sum} helper for the adder arbiter.
// Build option: TT_ADDER_ARB_SAT_EN selects unsigned saturation.
package tt_adder_arb_pkg;

    localparam int ADDER_WIDTH = 8;
    localparam int ADDER_NREQ  = 4;

    typedef logic [$clog2(ADDER_NREQ)-1:0] req_id_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_t;

    function automatic logic [ADDER_WIDTH:0] sat_add(
        input logic [ADDER_WIDTH-1:0] a,
        input logic [ADDER_WIDTH-1:0] b
    );
        logic [ADDER_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef TT_ADDER_ARB_SAT_EN
        // all ones = saturation flag plus a full-scale sum
        if (s[ADDER_WIDTH]) s = '1;
`endif
        return s;
    endfunction

endpackage

// File: rtl/tt_adder_arbiter_if.sv
// Request and response channels of the shared-adder arbiter.
// Requester i occupies bits [i*WIDTH +: WIDTH] of req_a/req_b.
interface tt_adder_arbiter_if
    import tt_adder_arb_pkg::*;
#(
    parameter int NREQ  = ADDER_NREQ,
    parameter int WIDTH = ADDER_WIDTH
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_carry;
    logic [IDW-1:0]        rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
    );

endinterface

// File: rtl/tt_rr_arbiter.sv
// Combinational round-robin grant: first valid at or after i_ptr.
// Produces one-hot grant, its index and an any-valid flag.
module tt_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!o_any && i_valid[(int'(i_ptr) + k) % NREQ]) begin
                o_any = 1'b1;
                o_grant[(int'(i_ptr) + k) % NREQ] = 1'b1;
                o_idx = IDW'((int'(i_ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/tt_adder_arbiter.sv
// Round-robin sharing of one registered adder among NREQ requesters.
// Build option: TT_ADDER_ARB_SAT_EN saturates the sum instead of wrapping.
module tt_adder_arbiter
    import tt_adder_arb_pkg::*;
#(
    parameter int NREQ  = ADDER_NREQ,
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    tt_adder_arbiter_if.slave bus
);

    localparam int IDW = $clog2(NREQ);

    rsp_state_t       r_state;
    rsp_state_t       w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_gidx;
    logic             w_any;
    logic             w_acc;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_res;

    tt_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .i_valid (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    assign w_a = bus.req_a[int'(w_gidx)*WIDTH +: WIDTH];
    assign w_b = bus.req_b[int'(w_gidx)*WIDTH +: WIDTH];

    generate
        if (WIDTH == ADDER_WIDTH) begin : g_pkg_add
            assign w_res = sat_add(w_a, w_b);
        end else begin : g_gen_add
            always_comb begin
                w_res = {1'b0, w_a} + {1'b0, w_b};
`ifdef TT_ADDER_ARB_SAT_EN
                if (w_res[WIDTH]) w_res = '1;
`endif
            end
        end
    endgenerate

    // The result register is the whole FSM: FULL means rsp_valid.
    always_comb begin
        w_state_nxt = r_state;
        w_acc       = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                w_acc = w_any;
                if (w_any) w_state_nxt = ST_FULL;
            end
            ST_FULL: begin
                w_acc = bus.rsp_ready && w_any;
                if (bus.rsp_ready && !w_any) w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else if (w_acc) begin
            r_sum   <= w_res[WIDTH-1:0];
            r_carry <= w_res[WIDTH];
            r_id    <= w_gidx;
            r_ptr   <= (w_gidx == IDW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
        end
    end

    assign bus.req_ready = (w_acc && !rst) ? w_grant : '0;
    assign bus.rsp_valid = (r_state == ST_FULL);
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_carry = r_carry;
    assign bus.rsp_id    = r_id;

endmodule

// File: tb/tb_tt_adder_arbiter.sv
// Directed bench for tt_adder_arbiter: vector table plus handshake sequences.
// Expected overflow values follow TT_ADDER_ARB_SAT_EN when it is defined.
module tb_tt_adder_arbiter;
    import tt_adder_arb_pkg::*;

    typedef struct {
        req_id_t    id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       carry;
    } vec_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    vec_t vt[6];

    tt_adder_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

    tt_adder_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, got timeout, want summary");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        vt[0] = '{2'd2, 8'h12, 8'h34, 8'h46, 1'b0};
`ifdef TT_ADDER_ARB_SAT_EN
        vt[1] = '{2'd0, 8'hF0, 8'h20, 8'hFF, 1'b1};
        vt[2] = '{2'd1, 8'hFF, 8'h01, 8'hFF, 1'b1};
        vt[5] = '{2'd1, 8'hFF, 8'hFF, 8'hFF, 1'b1};
`else
        vt[1] = '{2'd0, 8'hF0, 8'h20, 8'h10, 1'b1};
        vt[2] = '{2'd1, 8'hFF, 8'h01, 8'h00, 1'b1};
        vt[5] = '{2'd1, 8'hFF, 8'hFF, 8'hFE, 1'b1};
`endif
        vt[3] = '{2'd3, 8'h80, 8'h7F, 8'hFF, 1'b0};
        vt[4] = '{2'd3, 8'h00, 8'h00, 8'h00, 1'b0};

        // reset with valids high: no grant may leak out
        rst           = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        #1;
        chk("rst_ready", bus.req_ready, 0);
        tick();
        chk("rst_valid", bus.rsp_valid, 0);
        bus.req_valid = 4'h0;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_out", {bus.req_ready, bus.rsp_valid, bus.rsp_sum,
                             bus.rsp_carry, bus.rsp_id}, 0);
        end

        // single-requester vectors, back to back
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.req_valid = 4'b0001 << vt[i].id;
            bus.req_a = '0;
            bus.req_b = '0;
            bus.req_a[vt[i].id*8 +: 8] = vt[i].a;
            bus.req_b[vt[i].id*8 +: 8] = vt[i].b;
            #1;
            chk("vec_ready", bus.req_ready, 4'b0001 << vt[i].id);
            tick();
            bus.req_valid = 4'h0;
            chk("vec_valid", bus.rsp_valid, 1);
            chk("vec_sum", bus.rsp_sum, vt[i].sum);
            chk("vec_carry", bus.rsp_carry, vt[i].carry);
            chk("vec_id", bus.rsp_id, vt[i].id);
        end
        tick();
        chk("drain_valid", bus.rsp_valid, 0);
        chk("drain_hold", {bus.rsp_sum, bus.rsp_carry, bus.rsp_id},
            {vt[5].sum, vt[5].carry, vt[5].id});

        // fresh pointer for the round-robin run
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_a     = {8'h04, 8'h03, 8'h02, 8'h01};
        bus.req_b     = {8'h10, 8'h10, 8'h10, 8'h10};
        bus.req_valid = 4'hF;
        #1;
        chk("rr_first", bus.req_ready, 4'b0001);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_valid", bus.rsp_valid, 1);
            chk("rr_id", bus.rsp_id, k % 4);
            chk("rr_sum", bus.rsp_sum, 8'h11 + (k % 4));
            chk("rr_ready", bus.req_ready, 4'b0001 << ((k + 1) % 4));
        end

        // stall with requesters 1 and 3 pending; id3 result is held
        bus.req_valid = 4'b1010;
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_ready", bus.req_ready, 0);
            chk("bp_hold", {bus.rsp_valid, bus.rsp_sum, bus.rsp_carry,
                            bus.rsp_id}, {1'b1, 8'h14, 1'b0, 2'd3});
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release", bus.req_ready, 4'b0010);
        tick();
        chk("bp_result", {bus.rsp_valid, bus.rsp_sum, bus.rsp_id},
            {1'b1, 8'h12, 2'd1});

        // reset while FULL and stalled
        bus.req_valid = 4'h0;
        bus.rsp_ready = 1'b0;
        tick();
        chk("ms_full", bus.rsp_valid, 1);
        bus.req_valid = 4'hF;
        #3;
        rst = 1'b1;
        #1;
        chk("ms_drop", {bus.rsp_valid, bus.rsp_sum, bus.rsp_id}, 0);
        chk("ms_ready", bus.req_ready, 0);
        tick();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        chk("ms_ptr0", bus.req_ready, 4'b0001);
        tick();
        chk("ms_result", {bus.rsp_valid, bus.rsp_sum, bus.rsp_id},
            {1'b1, 8'h11, 2'd0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
